// File: rtl/fpu_writeback_pkg.sv
// Shared FP writeback definitions: ftype encodings, fflags bit positions,
// entry field widths and the result-routing helper.
package fpu_writeback_pkg;

  localparam int unsigned DEF_FLEN  = 32;
  localparam int unsigned DEF_XLEN  = 64;
  localparam int unsigned DEF_DEPTH = 2;

  localparam int unsigned FTYPE_W  = 5;
  localparam int unsigned RD_W     = 5;
  localparam int unsigned FFLAGS_W = 5;

  localparam int unsigned FFLAG_NV = 4;
  localparam int unsigned FFLAG_DZ = 3;
  localparam int unsigned FFLAG_OF = 2;
  localparam int unsigned FFLAG_UF = 1;
  localparam int unsigned FFLAG_NX = 0;

  typedef enum logic [FTYPE_W-1:0] {
    FT_FADD     = 5'd0,
    FT_FSUB     = 5'd1,
    FT_FMUL     = 5'd2,
    FT_FDIV     = 5'd3,
    FT_FSQRT    = 5'd4,
    FT_FMADD    = 5'd5,
    FT_FMSUB    = 5'd6,
    FT_FNMSUB   = 5'd7,
    FT_FNMADD   = 5'd8,
    FT_FCVT_W   = 5'd9,
    FT_FCVT_WU  = 5'd10,
    FT_FCVT_L   = 5'd11,
    FT_FCVT_LU  = 5'd12,
    FT_FSGNJ    = 5'd13,
    FT_FSGNJN   = 5'd14,
    FT_FSGNJX   = 5'd15,
    FT_FMIN     = 5'd16,
    FT_FMAX     = 5'd17,
    FT_FCVT_S_X = 5'd18,
    FT_FMV_W_X  = 5'd19,
    FT_FEQ      = 5'd20,
    FT_FLT      = 5'd21,
    FT_FLE      = 5'd22,
    FT_FCLASS   = 5'd23
  } ftype_e;

  typedef enum logic [1:0] {
    DEST_NONE = 2'd0,
    DEST_FP   = 2'd1,
    DEST_INT  = 2'd2
  } wb_dest_e;

  function automatic wb_dest_e ft_dest(input logic [FTYPE_W-1:0] ftype);
    wb_dest_e d;
    d = DEST_NONE;
    case (ftype) inside
      [FT_FADD:FT_FNMADD], [FT_FSGNJ:FT_FMV_W_X]: d = DEST_FP;
      [FT_FCVT_W:FT_FCVT_LU], [FT_FEQ:FT_FCLASS]: d = DEST_INT;
      default:                                    d = DEST_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/fpu_writeback_if.sv
// Execute-to-writeback result bus and register-file write ports.
interface fpu_writeback_if
  import fpu_writeback_pkg::*;
#(
  parameter int unsigned FLEN = DEF_FLEN,
  parameter int unsigned XLEN = DEF_XLEN
);
  logic                in_valid;
  logic                in_ready;
  logic [FTYPE_W-1:0]  in_ftype;
  logic [RD_W-1:0]     in_rd;
  logic [FLEN-1:0]     in_farith;
  logic [31:0]         in_wconv;
  logic [63:0]         in_lconv;
  logic                in_cmp;
  logic [XLEN-1:0]     in_class;
  logic [FFLAGS_W-1:0] in_flags;

  logic                fp_wb_valid;
  logic [RD_W-1:0]     fp_wb_rd;
  logic [FLEN-1:0]     fp_wb_data;
  logic                int_wb_valid;
  logic [RD_W-1:0]     int_wb_rd;
  logic [XLEN-1:0]     int_wb_data;
  logic                wb_ready;

  modport slave (
    input  in_valid, in_ftype, in_rd, in_farith, in_wconv, in_lconv,
           in_cmp, in_class, in_flags, wb_ready,
    output in_ready, fp_wb_valid, fp_wb_rd, fp_wb_data,
           int_wb_valid, int_wb_rd, int_wb_data
  );

  modport master (
    output in_valid, in_ftype, in_rd, in_farith, in_wconv, in_lconv,
           in_cmp, in_class, in_flags, wb_ready,
    input  in_ready, fp_wb_valid, fp_wb_rd, fp_wb_data,
           int_wb_valid, int_wb_rd, int_wb_data
  );
endinterface

// File: rtl/fpu_wb_fifo.sv
// Generic DEPTH-entry synchronous FIFO with flush; occupancy count drives full/empty.
module fpu_wb_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/fpu_writeback.sv
// FP writeback stage: formats execute results at enqueue, buffers them, routes the
// head to the FP or integer regfile port and accrues sticky fflags on commit.
module fpu_writeback
  import fpu_writeback_pkg::*;
#(
  parameter int unsigned FLEN  = DEF_FLEN,
  parameter int unsigned XLEN  = DEF_XLEN,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  fpu_writeback_if.slave      bus,
  input  logic                csr_we,
  input  logic [FFLAGS_W-1:0] csr_wdata,
  output logic [FFLAGS_W-1:0] fflags
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic                is_int;
    logic [RD_W-1:0]     rd;
    logic [XLEN-1:0]     data;
    logic [FFLAGS_W-1:0] flags;
  } wb_entry_t;

  wb_entry_t     in_entry;
  wb_entry_t     head;
  wb_dest_e      dest;
  logic          full;
  logic          push;
  logic          deq;
  logic          head_valid;
  logic [CW-1:0] count;

  always_comb begin
    dest            = ft_dest(bus.in_ftype);
    in_entry        = '0;
    in_entry.is_int = (dest == DEST_INT);
    in_entry.rd     = bus.in_rd;
    in_entry.flags  = bus.in_flags;
    case (bus.in_ftype) inside
      FT_FCVT_W, FT_FCVT_WU: in_entry.data = XLEN'($signed(bus.in_wconv));
      FT_FCVT_L, FT_FCVT_LU: in_entry.data = XLEN'(bus.in_lconv);
      [FT_FEQ:FT_FLE]:       in_entry.data = XLEN'(bus.in_cmp);
      FT_FCLASS:             in_entry.data = bus.in_class;
      default:               in_entry.data = XLEN'(bus.in_farith);
    endcase
  end

  // Reserved ftypes are handshaken but never stored, so their flags vanish.
  assign bus.in_ready = !full;
  assign push         = bus.in_valid && !full && !flush && (dest != DEST_NONE);
  assign head_valid   = (count != '0);
  assign deq          = head_valid && bus.wb_ready && !flush;

  fpu_wb_fifo #(
    .WIDTH ($bits(wb_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .wdata (in_entry),
    .pop   (deq),
    .rdata (head),
    .full  (full),
    .count (count)
  );

  assign bus.fp_wb_valid  = head_valid && !head.is_int;
  assign bus.int_wb_valid = head_valid &&  head.is_int;
  assign bus.fp_wb_rd     = bus.fp_wb_valid  ? head.rd              : '0;
  assign bus.fp_wb_data   = bus.fp_wb_valid  ? head.data[FLEN-1:0]  : '0;
  assign bus.int_wb_rd    = bus.int_wb_valid ? head.rd              : '0;
  assign bus.int_wb_data  = bus.int_wb_valid ? head.data            : '0;

  // CSR write and commit merge so a same-cycle commit is never overwritten.
  always_ff @(posedge clk) begin
    if (rst) fflags <= '0;
    else     fflags <= (csr_we ? csr_wdata : fflags) | (deq ? head.flags : '0);
  end
endmodule
